wb_queue: RTL

- Writeback buffer directly upstream of the 32x64 dual-write register file.
- Accepts up to two results per cycle from execute and holds them in program order in a FIFO.
- Drains up to two entries per cycle onto the register file's write_port1/write_port2/write_data1/write_data2/write interface.
- Absorbs stalls and bursts so execute never writes the register file directly.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo_mem.sv | 31 +++
 rtl/wb_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback buffer constants and entry type
package wb_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DEPTH  = 8;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_mem.sv
// rtl/wb_fifo_mem.sv - DEPTH-entry storage with two write and two read ports
module wb_fifo_mem #(
    parameter int W     = 69,
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          wa_en_i,
    input  logic [PW-1:0] wa_ptr_i,
    input  logic [W-1:0]  wa_data_i,
    input  logic          wb_en_i,
    input  logic [PW-1:0] wb_ptr_i,
    input  logic [W-1:0]  wb_data_i,
    input  logic [PW-1:0] ra_ptr_i,
    output logic [W-1:0]  ra_data_o,
    input  logic [PW-1:0] rb_ptr_i,
    output logic [W-1:0]  rb_data_o
);

    logic [W-1:0] mem_q [DEPTH];

    // The two write pointers are always distinct slots, so order between them is irrelevant.
    always_ff @(posedge clk) begin
        if (wa_en_i) mem_q[wa_ptr_i] <= wa_data_i;
        if (wb_en_i) mem_q[wb_ptr_i] <= wb_data_i;
    end

    assign ra_data_o = mem_q[ra_ptr_i];
    assign rb_data_o = mem_q[rb_ptr_i];

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - dual-lane in-order writeback FIFO feeding the dual-write register file
module wb_queue
    import wb_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DEPTH   = WB_DEPTH,
    parameter int DROP_R0 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in0_valid,
    input  logic [ADDR_W-1:0]        in0_addr,
    input  logic [DATA_W-1:0]        in0_data,
    input  logic                     in1_valid,
    input  logic [ADDR_W-1:0]        in1_addr,
    input  logic [DATA_W-1:0]        in1_data,
    output logic                     in_ready,
    input  logic                     drain_en,
    output logic                     write,
    output logic [ADDR_W-1:0]        write_port1,
    output logic [DATA_W-1:0]        write_data1,
    output logic [ADDR_W-1:0]        write_port2,
    output logic [DATA_W-1:0]        write_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] port1_q, port1_d, port2_q, port2_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic              full_q, empty_q;

    logic              acc0, acc1, pop1, pop2;
    logic [1:0]        n_push, n_pop;
    logic              wa_en, wb_en;
    logic [EW-1:0]     wa_data, wb_data, ra_data, rb_data;

    assign in_ready = (CW'(DEPTH) - count_q) >= CW'(2);

    always_comb begin
        acc0    = in0_valid && in_ready && !((DROP_R0 != 0) && (in0_addr == '0));
        acc1    = in1_valid && in_ready && !((DROP_R0 != 0) && (in1_addr == '0));
        n_push  = {1'b0, acc0} + {1'b0, acc1};
        pop2    = drain_en && (count_q >= CW'(2));
        pop1    = drain_en && (count_q == CW'(1));
        n_pop   = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);

        // Oldest accepted lane always lands at tail so a lone lane1 takes one slot.
        wa_en   = acc0 || acc1;
        wa_data = acc0 ? {in0_addr, in0_data} : {in1_addr, in1_data};
        wb_en   = acc0 && acc1;
        wb_data = {in1_addr, in1_data};

        head_d  = head_q + PW'(n_pop);
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(n_pop);

        write_d = pop1 || pop2;
        port1_d = port1_q;
        data1_d = data1_q;
        port2_d = port2_q;
        data2_d = data2_q;
        if (pop2) begin
            port2_d = ra_data[DATA_W +: ADDR_W];
            data2_d = ra_data[DATA_W-1:0];
            port1_d = rb_data[DATA_W +: ADDR_W];
            data1_d = rb_data[DATA_W-1:0];
        end else if (pop1) begin
            // Register file writes both ports on write=1, so a single entry goes on both.
            port2_d = ra_data[DATA_W +: ADDR_W];
            data2_d = ra_data[DATA_W-1:0];
            port1_d = ra_data[DATA_W +: ADDR_W];
            data1_d = ra_data[DATA_W-1:0];
        end
    end

    wb_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk       (clk),
        .wa_en_i   (wa_en),
        .wa_ptr_i  (tail_q),
        .wa_data_i (wa_data),
        .wb_en_i   (wb_en),
        .wb_ptr_i  (tail_q + PW'(1)),
        .wb_data_i (wb_data),
        .ra_ptr_i  (head_q),
        .ra_data_o (ra_data),
        .rb_ptr_i  (head_q + PW'(1)),
        .rb_data_o (rb_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            write_q <= 1'b0;
            port1_q <= '0;
            data1_q <= '0;
            port2_q <= '0;
            data2_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            write_q <= write_d;
            port1_q <= port1_d;
            data1_q <= data1_d;
            port2_q <= port2_d;
            data2_q <= data2_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign write       = write_q;
    assign write_port1 = port1_q;
    assign write_data1 = data1_q;
    assign write_port2 = port2_q;
    assign write_data2 = data2_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule
